// File: rtl/cpu_cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between icache (0) and dcache (1).
// One transaction in flight: latch winner, hold it on the memory port, return a one-cycle response.
module cpu_cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  c0_read,
  input  logic                  c0_write,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [LINE_WIDTH-1:0] c0_data,
  output logic                  c0_rsp_valid,
  output logic [LINE_WIDTH-1:0] c0_rsp_data,
  input  logic                  c1_read,
  input  logic                  c1_write,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [LINE_WIDTH-1:0] c1_data,
  output logic                  c1_rsp_valid,
  output logic [LINE_WIDTH-1:0] c1_rsp_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_data,
  input  logic                  mem_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rsp_addr,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  output logic                  grant,
  output logic                  busy,
  output logic                  timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t                         state;
  logic                           last;
  logic [7:0]                     cnt;
  logic [7:0]                     cnt_inc;
  logic [1:0]                     rd, wr, req;
  logic [1:0][ADDR_WIDTH-1:0]     addr;
  logic [1:0][LINE_WIDTH-1:0]     data;
  logic [1:0]                     rsp_valid;
  logic [1:0][LINE_WIDTH-1:0]     rsp_data;
  logic                           win;

  assign rd   = {c1_read, c0_read};
  assign wr   = {c1_write, c0_write};
  assign req  = rd | wr;
  assign addr = {c1_addr, c0_addr};
  assign data = {c1_data, c0_data};

  // On a tie the client that was not served last wins; otherwise the lone requester.
  assign win     = (req == 2'b11) ? ~last : req[1];
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  assign busy         = (state != IDLE);
  assign c0_rsp_valid = rsp_valid[0];
  assign c1_rsp_valid = rsp_valid[1];
  assign c0_rsp_data  = rsp_data[0];
  assign c1_rsp_data  = rsp_data[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      grant     <= 1'b0;
      timeout   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= win;
            mem_read  <= rd[win] & ~wr[win];
            mem_write <= wr[win];
            mem_addr  <= addr[win];
            mem_data  <= data[win];
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (cnt_inc >= TO) timeout <= 1'b1;
          // mem_addr doubles as the latched request address for response matching
          if (mem_rsp_valid && mem_rsp_addr == mem_addr) begin
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            rsp_valid[grant] <= 1'b1;
            rsp_data[grant]  <= mem_rsp_data;
            state            <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          last      <= grant;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_cache_mem_arbiter.sv
// Directed bench for cpu_cache_mem_arbiter: one task per scenario, inline checks.
module tb_cpu_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          c0_read = 0, c0_write = 0, c1_read = 0, c1_write = 0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [LW-1:0] c0_data = '0, c1_data = '0;
  logic          c0_rsp_valid, c1_rsp_valid;
  logic [LW-1:0] c0_rsp_data, c1_rsp_data;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data;
  logic          mem_rsp_valid = 0;
  logic [AW-1:0] mem_rsp_addr = '0;
  logic [LW-1:0] mem_rsp_data = '0;
  logic          grant, busy, timeout;

  int checks = 0;
  int failures = 0;

  localparam logic [LW-1:0] D1   = 128'hDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA;
  localparam logic [LW-1:0] L0   = 128'h00000000_00000000_00000000_0000C0C0;
  localparam logic [LW-1:0] L1   = 128'h11110000_00000000_00000000_0000C1C1;
  localparam logic [LW-1:0] ONES = 128'h11111111111111111111111111111111;

  cpu_cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr), .c0_data(c0_data),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr), .c1_data(c1_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, mem_read, mem_write, grant, timeout, c0_rsp_valid, c1_rsp_valid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {busy, mem_read, mem_write, grant, timeout, c0_rsp_valid, c1_rsp_valid});
    end
    checks++;
    if (mem_addr !== '0 || mem_data !== '0 || c0_rsp_data !== '0 || c1_rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%0h data=%0h", mem_addr, mem_data);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_read;
    c0_read = 1; c0_addr = 32'h0;
    tick();
    checks++;
    if (mem_read !== 1 || mem_addr !== 32'h0 || busy !== 1 || grant !== 0) begin
      failures++;
      $display("FAIL t1_issue rd=%b addr=%0h busy=%b grant=%b exp rd=1 addr=0 busy=1 grant=0", mem_read, mem_addr, busy, grant);
    end
    tick();
    checks++;
    if (mem_read !== 1 || c0_rsp_valid !== 0) begin
      failures++;
      $display("FAIL t1_hold rd=%b rspv=%b exp 1 0", mem_read, c0_rsp_valid);
    end
    tick();
    mem_rsp_valid = 1; mem_rsp_addr = 32'h0; mem_rsp_data = D1;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (c0_rsp_valid !== 1 || c0_rsp_data !== D1 || c1_rsp_valid !== 0 || c1_rsp_data !== '0 || mem_read !== 0) begin
      failures++;
      $display("FAIL t1_resp v0=%b d0=%0h v1=%b rd=%b exp v0=1 d0=%0h v1=0 rd=0", c0_rsp_valid, c0_rsp_data, c1_rsp_valid, mem_read, D1);
    end
    c0_read = 0;
    tick();
    checks++;
    if (c0_rsp_valid !== 0 || busy !== 0 || c0_rsp_data !== D1) begin
      failures++;
      $display("FAIL t1_done v0=%b busy=%b d0=%0h exp v0=0 busy=0 d0 held", c0_rsp_valid, busy, c0_rsp_data);
    end
  endtask

  task automatic test_tie;
    do_reset();
    c0_read = 1; c0_addr = 32'h10;
    c1_read = 1; c1_addr = 32'h20;
    tick();
    checks++;
    if (grant !== 0 || mem_addr !== 32'h10 || mem_read !== 1) begin
      failures++;
      $display("FAIL t2_first grant=%b addr=%0h exp grant=0 addr=10", grant, mem_addr);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h10; mem_rsp_data = L0;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (c0_rsp_valid !== 1 || c0_rsp_data !== L0 || c1_rsp_valid !== 0) begin
      failures++;
      $display("FAIL t2_rsp0 v0=%b d0=%0h v1=%b exp 1 %0h 0", c0_rsp_valid, c0_rsp_data, c1_rsp_valid, L0);
    end
    c0_read = 0;
    tick();
    checks++;
    if (busy !== 0 || grant !== 0) begin
      failures++;
      $display("FAIL t2_idle busy=%b grant=%b exp 0 0", busy, grant);
    end
    tick();
    checks++;
    if (grant !== 1 || mem_addr !== 32'h20 || mem_read !== 1) begin
      failures++;
      $display("FAIL t2_second grant=%b addr=%0h exp grant=1 addr=20", grant, mem_addr);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h20; mem_rsp_data = L1;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (c1_rsp_valid !== 1 || c1_rsp_data !== L1 || c0_rsp_valid !== 0 || c0_rsp_data !== L0) begin
      failures++;
      $display("FAIL t2_rsp1 v1=%b d1=%0h v0=%b d0=%0h exp 1 %0h 0 %0h", c1_rsp_valid, c1_rsp_data, c0_rsp_valid, c0_rsp_data, L1, L0);
    end
    c1_read = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ea;
    c0_read = 1; c0_addr = 32'h100;
    c1_read = 1; c1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2 == 0) ? 32'h100 : 32'h200;
      tick();
      checks++;
      if (grant !== 1'(i % 2) || mem_addr !== ea) begin
        failures++;
        $display("FAIL t3_grant%0d grant=%b addr=%0h exp grant=%0d addr=%0h", i, grant, mem_addr, i % 2, ea);
      end
      mem_rsp_valid = 1; mem_rsp_addr = ea; mem_rsp_data = {96'h0, ea};
      tick();
      mem_rsp_valid = 0;
      checks++;
      if ({c1_rsp_valid, c0_rsp_valid} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL t3_rsp%0d v1v0=%b%b exp client %0d", i, c1_rsp_valid, c0_rsp_valid, i % 2);
      end
      tick();
    end
    c0_read = 0; c1_read = 0;
    tick();
  endtask

  task automatic test_write_mismatch;
    c1_write = 1; c1_addr = 32'h40; c1_data = ONES;
    tick();
    checks++;
    if (mem_write !== 1 || mem_read !== 0 || mem_data !== ONES || mem_addr !== 32'h40 || grant !== 1) begin
      failures++;
      $display("FAIL t4_issue wr=%b rd=%b addr=%0h data=%0h grant=%b", mem_write, mem_read, mem_addr, mem_data, grant);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h80; mem_rsp_data = L0;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (busy !== 1 || c1_rsp_valid !== 0 || mem_write !== 1 || mem_data !== ONES) begin
      failures++;
      $display("FAIL t4_mismatch busy=%b v1=%b wr=%b exp busy=1 v1=0 wr=1", busy, c1_rsp_valid, mem_write);
    end
    tick();
    mem_rsp_valid = 1; mem_rsp_addr = 32'h40; mem_rsp_data = L1;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (c1_rsp_valid !== 1 || c0_rsp_valid !== 0 || mem_write !== 0) begin
      failures++;
      $display("FAIL t4_resp v1=%b v0=%b wr=%b exp 1 0 0", c1_rsp_valid, c0_rsp_valid, mem_write);
    end
    c1_write = 0;
    tick();
  endtask

  task automatic test_timeout;
    c0_read = 1; c0_addr = 32'h300;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    checks++;
    if (timeout !== 0) begin
      failures++;
      $display("FAIL t5_early timeout=%b exp 0", timeout);
    end
    tick();
    checks++;
    if (timeout !== 1 || mem_read !== 1 || busy !== 1) begin
      failures++;
      $display("FAIL t5_flag timeout=%b rd=%b busy=%b exp 1 1 1", timeout, mem_read, busy);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h300; mem_rsp_data = D1;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (c0_rsp_valid !== 1 || c0_rsp_data !== D1 || timeout !== 1) begin
      failures++;
      $display("FAIL t5_late v0=%b d0=%0h timeout=%b exp 1 %0h 1", c0_rsp_valid, c0_rsp_data, timeout, D1);
    end
    c0_read = 0;
    tick();
    checks++;
    if (timeout !== 1 || busy !== 0) begin
      failures++;
      $display("FAIL t5_sticky timeout=%b busy=%b exp 1 0", timeout, busy);
    end
  endtask

  task automatic test_reset_mid_busy;
    c1_read = 1; c1_addr = 32'h500;
    tick();
    checks++;
    if (mem_read !== 1 || busy !== 1) begin
      failures++;
      $display("FAIL t6_busy rd=%b busy=%b exp 1 1", mem_read, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, mem_read, mem_write, grant, timeout, c0_rsp_valid, c1_rsp_valid} !== 7'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL t6_async ctrl=%b addr=%0h exp 0 0", {busy, mem_read, mem_write, grant, timeout, c0_rsp_valid, c1_rsp_valid}, mem_addr);
    end
    c1_read = 0;
    tick();
    reset = 1'b1;
    mem_rsp_valid = 1; mem_rsp_addr = 32'h500; mem_rsp_data = L1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) mem_rsp_addr = 32'h0;
      checks++;
      if (c0_rsp_valid !== 0 || c1_rsp_valid !== 0 || busy !== 0) begin
        failures++;
        $display("FAIL t6_stale%0d v0=%b v1=%b busy=%b exp 0 0 0", i, c0_rsp_valid, c1_rsp_valid, busy);
      end
    end
    mem_rsp_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_write_mismatch();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
